pipeline_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 22 ++
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: controller state encoding, register address width
// and the SYSTEM-opcode constants the decoder uses to raise a halt.
package cpu_pkg;

    localparam int unsigned NB_REG_ADDR = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_PAUSE  = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StRun    = ST_RUN,
        StStep   = ST_STEP,
        StPause  = ST_PAUSE,
        StDrain  = ST_DRAIN,
        StHalted = ST_HALTED
    } ctrl_state_e;

    localparam logic [6:0]  OPC_SYSTEM     = 7'b1110011;
    localparam logic [2:0]  FUNCT3_PRIV    = 3'b000;
    localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
    localparam logic [11:0] FUNCT12_EBREAK = 12'h001;

    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr[6:0] == OPC_SYSTEM) && (instr[14:12] == FUNCT3_PRIV) &&
               ((instr[31:20] == FUNCT12_ECALL) || (instr[31:20] == FUNCT12_EBREAK));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module hazard_detect #(
    parameter int unsigned NB_REG_ADDR = 5
) (
    input  logic [NB_REG_ADDR-1:0] i_id_rs1_addr,
    input  logic [NB_REG_ADDR-1:0] i_id_rs2_addr,
    input  logic                   i_id_uses_rs1,
    input  logic                   i_id_uses_rs2,
    input  logic                   i_ex_mem_read,
    input  logic [NB_REG_ADDR-1:0] i_ex_rd_addr,
    output logic                   o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
    // x0 is never written, so a load targeting it cannot create a dependency
    assign o_load_use = i_ex_mem_read && (i_ex_rd_addr != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: debug run/pause/step/halt FSM, stage enable/flush/bubble
// strobes, post-halt drain counter and retired-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned NB_REG_ADDR  = cpu_pkg::NB_REG_ADDR,
    parameter int unsigned NB_CNT       = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_pause,
    input  logic [NB_REG_ADDR-1:0] i_id_rs1_addr,
    input  logic [NB_REG_ADDR-1:0] i_id_rs2_addr,
    input  logic                   i_id_uses_rs1,
    input  logic                   i_id_uses_rs2,
    input  logic                   i_ex_memRead,
    input  logic [NB_REG_ADDR-1:0] i_ex_rd_addr,
    input  logic                   i_ex_jump_taken,
    input  logic                   i_id_halt,
    output logic                   o_pc_en,
    output logic                   o_if_id_en,
    output logic                   o_if_id_flush,
    output logic                   o_id_ex_en,
    output logic                   o_id_ex_bubble,
    output logic                   o_ex_mem_en,
    output logic                   o_mem_wb_en,
    output logic                   o_halted,
    output logic                   o_paused,
    output logic [NB_CNT-1:0]      o_cycle_cnt
);

    import cpu_pkg::*;

    localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    ctrl_state_e         r_state;
    ctrl_state_e         w_state_next;
    logic [NB_DRAIN-1:0] r_drain_cnt;
    logic [NB_CNT-1:0]   r_cycle_cnt;
    logic                w_load_use;
    logic                w_advance;
    logic                w_halt_take;

    hazard_detect #(
        .NB_REG_ADDR (NB_REG_ADDR)
    ) u_hazard_detect (
        .i_id_rs1_addr (i_id_rs1_addr),
        .i_id_rs2_addr (i_id_rs2_addr),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .i_ex_mem_read (i_ex_memRead),
        .i_ex_rd_addr  (i_ex_rd_addr),
        .o_load_use    (w_load_use)
    );

    assign w_advance   = (r_state == StRun) || (r_state == StStep);
    // A taken jump squashes the halt sitting in ID, so it must not start the drain
    assign w_halt_take = w_advance && i_id_halt && !i_ex_jump_taken;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StPause: begin
                if (i_run) begin
                    w_state_next = StRun;
                end else if (i_step) begin
                    w_state_next = StStep;
                end
            end
            StRun: begin
                if (w_halt_take) begin
                    w_state_next = StDrain;
                end else if (i_pause) begin
                    w_state_next = StPause;
                end
            end
            StStep:   w_state_next = w_halt_take ? StDrain : StPause;
            StDrain:  w_state_next = (r_drain_cnt == '0) ? StHalted : StDrain;
            StHalted: w_state_next = StHalted;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_ex_mem_en    = 1'b0;
        o_mem_wb_en    = 1'b0;
        o_halted       = 1'b0;
        o_paused       = 1'b0;
        case (r_state)
            StIdle, StPause: o_paused = 1'b1;
            StRun, StStep: begin
                o_pc_en     = 1'b1;
                o_if_id_en  = 1'b1;
                o_id_ex_en  = 1'b1;
                o_ex_mem_en = 1'b1;
                o_mem_wb_en = 1'b1;
                if (i_ex_jump_taken) begin
                    o_if_id_flush  = 1'b1;
                    o_id_ex_bubble = 1'b1;
                end else if (i_id_halt || w_load_use) begin
                    o_pc_en        = 1'b0;
                    o_if_id_en     = 1'b0;
                    o_id_ex_bubble = 1'b1;
                end
            end
            StDrain: begin
                o_id_ex_en     = 1'b1;
                o_id_ex_bubble = 1'b1;
                o_ex_mem_en    = 1'b1;
                o_mem_wb_en    = 1'b1;
            end
            StHalted: o_halted = 1'b1;
            default: o_paused = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_drain_cnt <= '0;
        end else if (w_halt_take) begin
            r_drain_cnt <= NB_DRAIN'(DRAIN_CYCLES - 1);
        end else if ((r_state == StDrain) && (r_drain_cnt != '0)) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle_cnt <= '0;
        end else if (o_mem_wb_en) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic checked
// against a mode-level behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned NB_REG_ADDR  = 5;
    localparam int unsigned NB_CNT       = 32;
    localparam int unsigned DRAIN_CYCLES = 3;

    logic                   clk;
    logic                   i_rst;
    logic                   i_run;
    logic                   i_step;
    logic                   i_pause;
    logic [NB_REG_ADDR-1:0] i_id_rs1_addr;
    logic [NB_REG_ADDR-1:0] i_id_rs2_addr;
    logic                   i_id_uses_rs1;
    logic                   i_id_uses_rs2;
    logic                   i_ex_memRead;
    logic [NB_REG_ADDR-1:0] i_ex_rd_addr;
    logic                   i_ex_jump_taken;
    logic                   i_id_halt;
    logic                   o_pc_en;
    logic                   o_if_id_en;
    logic                   o_if_id_flush;
    logic                   o_id_ex_en;
    logic                   o_id_ex_bubble;
    logic                   o_ex_mem_en;
    logic                   o_mem_wb_en;
    logic                   o_halted;
    logic                   o_paused;
    logic [NB_CNT-1:0]      o_cycle_cnt;

    pipeline_ctrl #(
        .NB_REG_ADDR  (NB_REG_ADDR),
        .NB_CNT       (NB_CNT),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_run           (i_run),
        .i_step          (i_step),
        .i_pause         (i_pause),
        .i_id_rs1_addr   (i_id_rs1_addr),
        .i_id_rs2_addr   (i_id_rs2_addr),
        .i_id_uses_rs1   (i_id_uses_rs1),
        .i_id_uses_rs2   (i_id_uses_rs2),
        .i_ex_memRead    (i_ex_memRead),
        .i_ex_rd_addr    (i_ex_rd_addr),
        .i_ex_jump_taken (i_ex_jump_taken),
        .i_id_halt       (i_id_halt),
        .o_pc_en         (o_pc_en),
        .o_if_id_en      (o_if_id_en),
        .o_if_id_flush   (o_if_id_flush),
        .o_id_ex_en      (o_id_ex_en),
        .o_id_ex_bubble  (o_id_ex_bubble),
        .o_ex_mem_en     (o_ex_mem_en),
        .o_mem_wb_en     (o_mem_wb_en),
        .o_halted        (o_halted),
        .o_paused        (o_paused),
        .o_cycle_cnt     (o_cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_err = 0;
    int n_chk = 0;

    // Reference model: what the controller is doing, not how it encodes it
    bit          m_running;
    bit          m_step_pending;
    bit          m_halted;
    int          m_drain_left;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running      = 0;
        m_step_pending = 0;
        m_halted       = 0;
        m_drain_left   = 0;
        m_cnt          = 0;
    endtask

    function automatic bit load_use();
        return i_ex_memRead && (i_ex_rd_addr != 0) &&
               ((i_id_uses_rs1 && i_id_rs1_addr == i_ex_rd_addr) ||
                (i_id_uses_rs2 && i_id_rs2_addr == i_ex_rd_addr));
    endfunction

    // {pc, if_id_en, flush, id_ex_en, bubble, ex_mem_en, mem_wb_en, halted, paused}
    function automatic logic [8:0] exp_vec();
        bit pc, ifid, fl, idex, bub, exm, mwb, hlt, pau;
        {pc, ifid, fl, idex, bub, exm, mwb, hlt, pau} = '0;
        if (i_rst) begin
            pau = 1;
        end else if (m_halted) begin
            hlt = 1;
        end else if (m_drain_left > 0) begin
            idex = 1; bub = 1; exm = 1; mwb = 1;
        end else if (m_running || m_step_pending) begin
            pc = 1; ifid = 1; idex = 1; exm = 1; mwb = 1;
            if (i_ex_jump_taken) begin
                fl = 1; bub = 1;
            end else if (i_id_halt || load_use()) begin
                pc = 0; ifid = 0; bub = 1;
            end
        end else begin
            pau = 1;
        end
        return {pc, ifid, fl, idex, bub, exm, mwb, hlt, pau};
    endfunction

    task automatic model_edge();
        logic [8:0] e;
        e = exp_vec();
        if (i_rst) begin
            model_reset();
        end else begin
            if (e[2]) m_cnt = m_cnt + 1;
            if (m_halted) begin
                m_halted = 1;
            end else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (m_running || m_step_pending) begin
                if (i_id_halt && !i_ex_jump_taken) begin
                    m_drain_left   = DRAIN_CYCLES;
                    m_running      = 0;
                    m_step_pending = 0;
                end else if (m_step_pending) begin
                    m_step_pending = 0;
                end else if (i_pause) begin
                    m_running = 0;
                end
            end else if (i_run) begin
                m_running = 1;
            end else if (i_step) begin
                m_step_pending = 1;
            end
        end
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic cyc();
        #1;
        if (i_rst) model_reset();
        check("strobes", {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_bubble,
                          o_ex_mem_en, o_mem_wb_en, o_halted, o_paused}, exp_vec());
        check("cycle_cnt", o_cycle_cnt, m_cnt);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_run = 0; i_step = 0; i_pause = 0;
        i_id_rs1_addr = 0; i_id_rs2_addr = 0; i_id_uses_rs1 = 0; i_id_uses_rs2 = 0;
        i_ex_memRead = 0; i_ex_rd_addr = 0; i_ex_jump_taken = 0; i_id_halt = 0;
    endtask

    task automatic random_inputs(input bit allow_halt);
        i_run           = ($urandom_range(0, 3) != 0);
        i_step          = $urandom_range(0, 1);
        i_pause         = ($urandom_range(0, 5) == 0);
        i_id_rs1_addr   = NB_REG_ADDR'($urandom_range(0, 3));
        i_id_rs2_addr   = NB_REG_ADDR'($urandom_range(0, 3));
        i_id_uses_rs1   = $urandom_range(0, 1);
        i_id_uses_rs2   = $urandom_range(0, 1);
        i_ex_memRead    = $urandom_range(0, 1);
        i_ex_rd_addr    = NB_REG_ADDR'($urandom_range(0, 3));
        i_ex_jump_taken = ($urandom_range(0, 4) == 0);
        i_id_halt       = allow_halt && ($urandom_range(0, 29) == 0);
    endtask

    logic [31:0] cnt_snap;

    initial begin
        model_reset();
        clear_inputs();
        i_rst = 1;
        @(negedge clk);
        cyc();
        cyc();
        i_rst = 0;

        // Run from idle: one idle cycle, then ten retired cycles
        i_run = 1;
        repeat (11) cyc();
        check("run_cnt10", o_cycle_cnt, 32'd10);

        // Load-use on rs1
        i_ex_memRead = 1; i_ex_rd_addr = 5; i_id_rs1_addr = 5; i_id_uses_rs1 = 1;
        #1;
        check("lu_stall", {o_pc_en, o_if_id_en, o_id_ex_bubble, o_mem_wb_en}, 4'b0011);
        cyc();
        // Same with rd = x0: no stall
        i_ex_rd_addr = 0; i_id_rs1_addr = 0;
        #1;
        check("lu_x0", {o_pc_en, o_if_id_en, o_id_ex_bubble}, 3'b110);
        cyc();
        // rs2 match used / unused
        i_ex_rd_addr = 7; i_id_rs1_addr = 1; i_id_rs2_addr = 7; i_id_uses_rs2 = 1;
        cyc();
        i_id_uses_rs2 = 0; i_id_uses_rs1 = 1;
        cyc();
        // Jump overrides load-use
        i_id_uses_rs2 = 1; i_ex_jump_taken = 1;
        #1;
        check("jump_over_lu", {o_pc_en, o_if_id_flush, o_id_ex_bubble}, 3'b111);
        cyc();
        clear_inputs();

        // Pause, then single-step
        i_pause = 1;
        cyc();
        i_pause = 0;
        repeat (2) cyc();
        cnt_snap = o_cycle_cnt;
        i_step = 1;
        cyc();
        i_step = 0;
        cyc();
        check("step_paused", o_paused, 1'b1);
        check("step_cnt", o_cycle_cnt, cnt_snap + 32'd1);
        repeat (2) cyc();
        // Step into a stall still advances only once
        i_step = 1; i_ex_memRead = 1; i_ex_rd_addr = 3; i_id_rs2_addr = 3; i_id_uses_rs2 = 1;
        cyc();
        i_step = 0;
        repeat (3) cyc();
        clear_inputs();

        for (int i = 0; i < 300; i++) begin
            random_inputs(1'b0);
            cyc();
        end
        clear_inputs();

        // Halt from RUN, drain, then ignore run/step
        i_run = 1;
        repeat (3) cyc();
        i_id_halt = 1;
        cyc();
        clear_inputs();
        repeat (DRAIN_CYCLES) cyc();
        check("halted", {o_halted, o_pc_en, o_mem_wb_en}, 3'b100);
        i_run = 1; i_step = 1;
        repeat (3) cyc();
        check("halted_sticky", o_halted, 1'b1);
        clear_inputs();

        // Reset asserted mid-drain takes effect before the next edge
        i_rst = 1;
        cyc();
        i_rst = 0; i_run = 1;
        repeat (2) cyc();
        i_id_halt = 1;
        cyc();
        i_id_halt = 0;
        cyc();
        #2;
        i_rst = 1;
        #1;
        model_reset();
        check("rst_async_en", {o_pc_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en}, 4'b0000);
        check("rst_async_cnt", o_cycle_cnt, 32'd0);
        check("rst_async_paused", o_paused, 1'b1);
        @(negedge clk);
        cyc();
        i_rst = 0;
        repeat (3) cyc();
        check("resume_run", {o_pc_en, o_mem_wb_en}, 2'b11);

        for (int i = 0; i < 500; i++) begin
            random_inputs(1'b1);
            i_rst = ($urandom_range(0, 79) == 0);
            cyc();
        end
        i_rst = 0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
